// File: rtl/posit_pkg.sv
`default_nettype none
// posit_pkg: NaR pattern, absolute-difference helper and checker state encoding.
package posit_pkg;

   localparam int MAX_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_ERR  = 2'd2
   } chk_state_t;

   // NaR is a single 1 in the sign position followed by zeros.
   function automatic logic [MAX_W-1:0] nar_pattern(input int n);
      logic [MAX_W-1:0] p;
      p        = '0;
      p[n-1]   = 1'b1;
      return p;
   endfunction

   function automatic logic [MAX_W-1:0] abs_diff(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

endpackage
`default_nettype wire

// File: rtl/posit_chk_fifo.sv
`default_nettype none
// posit_chk_fifo: synchronous first-word-fall-through FIFO holding expected posit words.
module posit_chk_fifo #(
   parameter  int N     = 32,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [N-1:0]  push_data,
   input  logic          pop,
   output logic [N-1:0]  head,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   fill
);

   logic [N-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // The extra pointer MSB separates the full and empty cases when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign fill  = wr_ptr - rd_ptr;
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/posit_result_checker.sv
`default_nettype none
// posit_result_checker: pairs unit results with queued expected words and keeps mismatch statistics.
// Optional POSIT_CHK_NAR_EN treats NaR specially (NaR==NaR matches, single NaR is a full-scale mismatch).
module posit_result_checker
   import posit_pkg::*;
#(
   parameter int N     = 32,
   parameter int DEPTH = 16,
   parameter int TOL   = 0,
   parameter int CNT_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       exp_valid,
   input  logic [N-1:0]               exp_data,
   output logic                       exp_ready,
   input  logic                       res_valid,
   input  logic [N-1:0]               res_data,
   output logic                       cmp_valid,
   output logic                       cmp_match,
   output logic [N-1:0]               cmp_diff,
   output logic [N-1:0]               cmp_exp,
   output logic [N-1:0]               cmp_res,
   output logic [CNT_W-1:0]           compare_cnt,
   output logic [CNT_W-1:0]           mismatch_cnt,
   output logic [N-1:0]               max_diff,
   output logic [CNT_W-1:0]           first_err_idx,
   output logic                       err_seen,
   output logic                       err_underflow,
   output logic                       err_overflow,
   output logic [$clog2(DEPTH):0]     fill
);

   localparam logic [N-1:0]     NAR     = N'(nar_pattern(N));
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic          full;
   logic          empty;
   logic [N-1:0]  head;
   logic          push;
   logic          pop;
   logic          underflow;
   logic          overflow;
   logic [N-1:0]  diff_c;
   logic          match_c;
   logic          mismatch;
   chk_state_t    state;

   assign exp_ready = !full;
   assign push      = exp_valid && !full;
   assign pop       = res_valid && !empty;
   assign underflow = res_valid && empty;
   assign overflow  = exp_valid && full;
   assign mismatch  = pop && !match_c;

   posit_chk_fifo #(
      .N     (N),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (exp_data),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .fill      (fill)
   );

   always_comb begin
      diff_c  = N'(abs_diff(MAX_W'(head), MAX_W'(res_data)));
      match_c = (diff_c <= N'(TOL));
`ifdef POSIT_CHK_NAR_EN
      if ((head == NAR) && (res_data == NAR)) begin
         diff_c  = '0;
         match_c = 1'b1;
      end else if ((head == NAR) || (res_data == NAR)) begin
         diff_c  = '1;
         match_c = 1'b0;
      end
`endif
   end

   // Comparison outputs and statistics are committed on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmp_valid     <= 1'b0;
         cmp_match     <= 1'b0;
         cmp_diff      <= '0;
         cmp_exp       <= '0;
         cmp_res       <= '0;
         compare_cnt   <= '0;
         mismatch_cnt  <= '0;
         max_diff      <= '0;
         first_err_idx <= '0;
         err_seen      <= 1'b0;
         err_underflow <= 1'b0;
         err_overflow  <= 1'b0;
      end else begin
         cmp_valid <= pop;
         if (pop) begin
            cmp_match <= match_c;
            cmp_diff  <= diff_c;
            cmp_exp   <= head;
            cmp_res   <= res_data;
            if (compare_cnt != CNT_MAX) compare_cnt <= compare_cnt + CNT_W'(1);
            if (diff_c > max_diff) max_diff <= diff_c;
            if (!match_c) begin
               if (mismatch_cnt != CNT_MAX) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
               if (!err_seen) first_err_idx <= compare_cnt;
               err_seen <= 1'b1;
            end
         end
         if (underflow) err_underflow <= 1'b1;
         if (overflow)  err_overflow  <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mismatch || underflow) state <= ST_ERR;
               else if (push)             state <= ST_RUN;
            end
            ST_RUN: begin
               if (mismatch || underflow) state <= ST_ERR;
            end
            ST_ERR:  state <= ST_ERR;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_posit_result_checker.sv
`default_nettype none
// tb_posit_result_checker: directed table, hand sequences and random traffic against a queue model.
module tb_posit_result_checker;

   localparam int          N     = 32;
   localparam int          DEPTH = 16;
   localparam int          TOL   = 0;
   localparam int          CNT_W = 32;
   localparam logic [31:0] NAR   = 32'h8000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        exp_valid = 1'b0;
   logic [31:0] exp_data = '0;
   logic        res_valid = 1'b0;
   logic [31:0] res_data = '0;

   logic        exp_ready, cmp_valid, cmp_match, err_seen, err_underflow, err_overflow;
   logic [31:0] cmp_diff, cmp_exp, cmp_res, max_diff;
   logic [31:0] compare_cnt, mismatch_cnt, first_err_idx;
   logic [4:0]  fill;

   logic        exp_ready_t, cmp_valid_t, cmp_match_t, err_seen_t, err_underflow_t, err_overflow_t;
   logic [31:0] cmp_diff_t, cmp_exp_t, cmp_res_t, max_diff_t;
   logic [31:0] compare_cnt_t, mismatch_cnt_t, first_err_idx_t;
   logic [4:0]  fill_t;

   posit_result_checker #(.N(N), .DEPTH(DEPTH), .TOL(TOL), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
      .res_valid(res_valid), .res_data(res_data), .cmp_valid(cmp_valid), .cmp_match(cmp_match),
      .cmp_diff(cmp_diff), .cmp_exp(cmp_exp), .cmp_res(cmp_res), .compare_cnt(compare_cnt),
      .mismatch_cnt(mismatch_cnt), .max_diff(max_diff), .first_err_idx(first_err_idx),
      .err_seen(err_seen), .err_underflow(err_underflow), .err_overflow(err_overflow), .fill(fill));

   // Second instance with a tolerance of 4, fed the same stimulus.
   posit_result_checker #(.N(N), .DEPTH(DEPTH), .TOL(4), .CNT_W(CNT_W)) dut_tol (
      .clk(clk), .rst(rst), .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready_t),
      .res_valid(res_valid), .res_data(res_data), .cmp_valid(cmp_valid_t), .cmp_match(cmp_match_t),
      .cmp_diff(cmp_diff_t), .cmp_exp(cmp_exp_t), .cmp_res(cmp_res_t), .compare_cnt(compare_cnt_t),
      .mismatch_cnt(mismatch_cnt_t), .max_diff(max_diff_t), .first_err_idx(first_err_idx_t),
      .err_seen(err_seen_t), .err_underflow(err_underflow_t), .err_overflow(err_overflow_t), .fill(fill_t));

   int tests  = 0;
   int failed = 0;

   logic [31:0] q[$];
   logic [31:0] m_cnt, m_mism, m_maxd, m_fidx, m_diff, m_exp, m_res;
   bit          m_seen, m_unf, m_ovf, m_cv, m_match;

   typedef struct {
      bit          ev;
      logic [31:0] ed;
      bit          rv;
      logic [31:0] rd;
      bit          cv;
      bit          m;
      logic [31:0] d;
   } vec_t;
   vec_t tbl[13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void ref_diff(input logic [31:0] e, input logic [31:0] r,
                                    output logic [31:0] d, output bit m);
      longint a = longint'(e);
      longint b = longint'(r);
      d = (a > b) ? 32'(a - b) : 32'(b - a);
      m = (d <= TOL);
`ifdef POSIT_CHK_NAR_EN
      if (e == NAR && r == NAR) begin
         d = 32'h0; m = 1'b1;
      end else if (e == NAR || r == NAR) begin
         d = 32'hFFFF_FFFF; m = 1'b0;
      end
`endif
   endfunction

   task automatic model_reset();
      q.delete();
      m_cnt = 0; m_mism = 0; m_maxd = 0; m_fidx = 0;
      m_seen = 0; m_unf = 0; m_ovf = 0; m_cv = 0;
   endtask

   task automatic model_step(input bit ev, input logic [31:0] ed, input bit rv, input logic [31:0] rd);
      int          sz = q.size();
      logic [31:0] e, d;
      bit          m;
      m_cv = 0;
      if (rv && sz == 0)     m_unf = 1;
      if (ev && sz == DEPTH) m_ovf = 1;
      if (rv && sz > 0) begin
         e = q.pop_front();
         ref_diff(e, rd, d, m);
         m_cv = 1; m_exp = e; m_res = rd; m_diff = d; m_match = m;
         if (d > m_maxd) m_maxd = d;
         if (!m) begin
            if (!m_seen) m_fidx = m_cnt;
            m_seen = 1;
            m_mism++;
         end
         m_cnt++;
      end
      if (ev && sz < DEPTH) q.push_back(ed);
   endtask

   task automatic check_all();
      check("cmp_valid", cmp_valid, m_cv);
      if (m_cv) begin
         check("cmp_diff", cmp_diff, m_diff);
         check("cmp_match", cmp_match, m_match);
         check("cmp_exp", cmp_exp, m_exp);
         check("cmp_res", cmp_res, m_res);
      end
      check("compare_cnt", compare_cnt, m_cnt);
      check("mismatch_cnt", mismatch_cnt, m_mism);
      check("max_diff", max_diff, m_maxd);
      check("err_seen", err_seen, m_seen);
      if (m_seen) check("first_err_idx", first_err_idx, m_fidx);
      check("err_underflow", err_underflow, m_unf);
      check("err_overflow", err_overflow, m_ovf);
      check("fill", fill, q.size());
      check("exp_ready", exp_ready, q.size() < DEPTH);
   endtask

   task automatic cycle(input bit ev, input logic [31:0] ed, input bit rv, input logic [31:0] rd);
      exp_valid = ev; exp_data = ed; res_valid = rv; res_data = rd;
      model_step(ev, ed, rv, rd);
      @(posedge clk);
      #1;
      exp_valid = 1'b0; res_valid = 1'b0;
      check_all();
   endtask

   task automatic do_reset(input bit rv);
      rst = 1'b1; exp_valid = 1'b1; exp_data = $urandom; res_valid = rv; res_data = $urandom;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0; exp_valid = 1'b0; res_valid = 1'b0;
      check_all();
   endtask

   initial begin
      logic [31:0] nar_zero_d;
      logic [31:0] rd;
      bit          ev, rv;
      int          pev;

`ifdef POSIT_CHK_NAR_EN
      nar_zero_d = 32'hFFFF_FFFF;
`else
      nar_zero_d = 32'h8000_0000;
`endif
      tbl[0]  = '{1'b1, 32'h4000_0000, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0};
      tbl[1]  = '{1'b1, 32'h4800_0000, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0};
      tbl[2]  = '{1'b0, 32'h0,         1'b1, 32'h4000_0000, 1'b1, 1'b1, 32'h0};
      tbl[3]  = '{1'b0, 32'h0,         1'b1, 32'h4800_0000, 1'b1, 1'b1, 32'h0};
      tbl[4]  = '{1'b1, 32'h4000_0000, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0};
      tbl[5]  = '{1'b0, 32'h0,         1'b1, 32'h3FFF_FFFE, 1'b1, 1'b0, 32'h2};
      tbl[6]  = '{1'b1, 32'h3FFF_FFFE, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0};
      tbl[7]  = '{1'b0, 32'h0,         1'b1, 32'h4000_0000, 1'b1, 1'b0, 32'h2};
      tbl[8]  = '{1'b1, NAR,           1'b0, 32'h0,         1'b0, 1'b0, 32'h0};
      tbl[9]  = '{1'b0, 32'h0,         1'b1, NAR,           1'b1, 1'b1, 32'h0};
      tbl[10] = '{1'b1, NAR,           1'b0, 32'h0,         1'b0, 1'b0, 32'h0};
      tbl[11] = '{1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 1'b0, nar_zero_d};
      tbl[12] = '{1'b1, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0};

      repeat (2) @(posedge clk);
      #1;
      do_reset(1'b0);

      for (int i = 0; i < 13; i++) begin
         cycle(tbl[i].ev, tbl[i].ed, tbl[i].rv, tbl[i].rd);
         check("tbl_cv", cmp_valid, tbl[i].cv);
         if (tbl[i].cv) begin
            check("tbl_match", cmp_match, tbl[i].m);
            check("tbl_diff", cmp_diff, tbl[i].d);
         end
         if (i == 3) check("tbl_cnt_after_two", compare_cnt, 32'd2);
         if (i == 7) begin
            check("tol4_match", cmp_match_t, 1'b1);
            check("tol4_err_seen", err_seen_t, 1'b0);
         end
      end
      check("tbl_compare_cnt", compare_cnt, 32'd6);
      check("tbl_mismatch_cnt", mismatch_cnt, 32'd3);
      check("tbl_first_err_idx", first_err_idx, 32'd2);
      check("tbl_max_diff", max_diff, nar_zero_d);
      check("tbl_underflow", err_underflow, 1'b1);
      check("tbl_fill", fill, 5'd1);

      // Fill to capacity, overflow, then pop while full and push+pop once not full.
      do_reset(1'b0);
      for (int k = 0; k < DEPTH; k++) cycle(1'b1, 32'h1000_0000 + k, 1'b0, 32'h0);
      check("full_ready", exp_ready, 1'b0);
      check("full_fill", fill, 5'd16);
      cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
      check("overflow_flag", err_overflow, 1'b1);
      cycle(1'b1, 32'hCAFE_0000, 1'b1, 32'h1000_0000);
      check("pop_when_full_fill", fill, 5'd15);
      cycle(1'b1, 32'hCAFE_0001, 1'b1, 32'h1000_0001);
      check("push_pop_fill", fill, 5'd15);
      for (int k = 0; k < 15; k++) cycle(1'b0, 32'h0, 1'b1, q[0]);
      check("drain_mismatch", mismatch_cnt, 32'd0);

      // Reset with entries queued and a comparison in flight.
      do_reset(1'b0);
      for (int k = 0; k < 3; k++) cycle(1'b1, 32'h2000_0000 + k, 1'b0, 32'h0);
      do_reset(1'b1);
      check("rst_fill", fill, 5'd0);
      check("rst_ready", exp_ready, 1'b1);
      check("rst_cmp_valid", cmp_valid, 1'b0);

      for (int c = 0; c < 3000; c++) begin
         pev = ((c / 300) % 2 == 0) ? 70 : 40;
         ev  = ($urandom_range(99) < pev);
         rv  = ($urandom_range(99) < 55);
         rd  = $urandom;
         if (q.size() > 0) begin
            case ($urandom_range(4))
               0, 1: rd = q[0];
               2:    rd = q[0] + 32'($urandom_range(3)) - 32'd1;
               3:    rd = NAR;
               default: rd = $urandom;
            endcase
         end
         if ($urandom_range(799) == 0) do_reset(rv);
         else cycle(ev, ($urandom_range(9) == 0) ? NAR : 32'($urandom), rv, rd);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
